// File: rtl/count_ctrl_pkg.sv
// Shared definitions for the count_ctrl block: FSM state encoding and helpers.
package count_ctrl_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    function automatic logic is_busy(input state_t s);
        return (s == ST_RUN) || (s == ST_PAUSED);
    endfunction

endpackage

// File: rtl/count_ctrl_tick_gen.sv
// Prescaler: free-running DIV_W-bit counter gated by en; tick on the all-ones cycle.
module tick_gen #(
    parameter int unsigned DIV_W = 22
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam logic [DIV_W-1:0] ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    logic [DIV_W-1:0] pre_q;
    logic [DIV_W-1:0] pre_d;

    always_comb begin
        pre_d = pre_q;
        if (clr) begin
            pre_d = '0;
        end else if (en) begin
            pre_d = pre_q + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    assign tick = en && !clr && (pre_q == '1);

endmodule

// File: rtl/count_ctrl.sv
// Prescaled up-counter with start/stop/pause control, one-shot or auto-reload modes.
module count_ctrl
    import count_ctrl_pkg::*;
#(
    parameter int unsigned DIV_W = 22,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             reload,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] cnt,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] limit_q, limit_d;
    logic             mode_q, mode_d;
    logic             done_q, done_d;

    logic tick;
    logic pre_en;
    logic pre_clr;

    // Prescaler only advances in an undisturbed RUN cycle; stop/start/pause take priority over tick.
    assign pre_en  = (state_q == ST_RUN) && !stop && !start && !pause;
    assign pre_clr = stop || start;

    tick_gen #(
        .DIV_W (DIV_W)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (pre_en),
        .clr  (pre_clr),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        limit_d = limit_q;
        mode_d  = mode_q;
        done_d  = 1'b0;

        if (stop) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (start) begin
            state_d = ST_RUN;
            cnt_d   = '0;
            limit_d = limit;
            mode_d  = reload;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (pause) begin
                        state_d = ST_PAUSED;
                    end else if (tick) begin
                        if (cnt_q == limit_q) begin
                            done_d = 1'b1;
                            if (mode_q) begin
                                cnt_d = '0;
                            end else begin
                                state_d = ST_DONE;
                            end
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                end
                ST_PAUSED: begin
                    if (!pause) begin
                        state_d = ST_RUN;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            limit_q <= '0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            limit_q <= limit_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
        end
    end

    assign cnt   = cnt_q;
    assign busy  = is_busy(state_q);
    assign done  = done_q;
    assign state = state_q;

endmodule
